// File: rtl/noc_pkg.sv
// noc_pkg: shared packet layout, FSM state type and header decode helpers
// for the NoC ingress buffer.
package noc_pkg;
    localparam int PKT_W   = 13;
    localparam int PORT_HI = 12;
    localparam int PORT_LO = 11;
    localparam int TYPE_HI = 10;
    localparam int TYPE_LO = 9;
    localparam logic [1:0] TYPE_RSVD = 2'b11;

    typedef enum logic [1:0] {IDLE, DECODE, WAIT_AVAIL, SEND} ingress_state_t;

    function automatic logic [1:0] pkt_type(input logic [PKT_W-1:0] p);
        return p[TYPE_HI:TYPE_LO];
    endfunction

    function automatic logic [1:0] pkt_port(input logic [PKT_W-1:0] p);
        return p[PORT_HI:PORT_LO];
    endfunction
endpackage

// File: rtl/noc_sync_fifo.sv
// noc_sync_fifo: single-clock power-of-two FIFO with count/full/empty;
// pushes when full and pops when empty are ignored.
module noc_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/noc_ingress_buffer.sv
// noc_ingress_buffer: queues ingress packets, drops reserved-type ones and
// hands the rest to the router with a request/available/ack handshake.
module noc_ingress_buffer #(
    parameter int DEPTH      = 4,
    parameter int PKT_W      = noc_pkg::PKT_W,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PKT_W-1:0]      packet,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  router_available,
    input  logic                  router_ack,
    output logic                  route_req,
    output logic [PKT_W-1:0]      out_packet,
    output logic [1:0]            out_port,
    output logic                  buffer_full,
    output logic [DROP_CNT_W-1:0] drop_count
);
    import noc_pkg::*;

    ingress_state_t           r_state;
    logic [PKT_W-1:0]         r_hold;
    logic                     r_route_req;
    logic [PKT_W-1:0]         r_out_packet;
    logic [1:0]               r_out_port;
    logic [DROP_CNT_W-1:0]    r_drop_count;
    logic [PKT_W-1:0]         w_head;
    logic [$clog2(DEPTH):0]   w_count;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_pop;

    assign ready       = w_count != ($clog2(DEPTH)+1)'(DEPTH);
    assign buffer_full = w_full;
    assign route_req   = r_route_req;
    assign out_packet  = r_out_packet;
    assign out_port    = r_out_port;
    assign drop_count  = r_drop_count;
    assign w_pop       = (r_state == IDLE) && !w_empty;

    noc_sync_fifo #(.DEPTH(DEPTH), .WIDTH(PKT_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (valid),
        .i_data  (packet),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_route_req  <= 1'b0;
            r_out_packet <= '0;
            r_out_port   <= '0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                IDLE: if (!w_empty) begin
                    r_hold  <= w_head;
                    r_state <= DECODE;
                end
                DECODE: if (pkt_type(r_hold) == TYPE_RSVD) begin
                    if (r_drop_count != '1) r_drop_count <= r_drop_count + 1'b1;
                    r_state <= IDLE;
                end else begin
                    r_out_port   <= pkt_port(r_hold);
                    r_out_packet <= r_hold;
                    r_state      <= WAIT_AVAIL;
                end
                WAIT_AVAIL: if (router_available) begin
                    r_route_req <= 1'b1;
                    r_state     <= SEND;
                end
                // Only the ack ends a transfer; availability is not re-checked here.
                SEND: if (router_ack) begin
                    r_route_req <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end
endmodule
